apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_LO, default 1000, meaning the lowest mapped APB address (inclusive).
REQ-002 SHALL have parameter ADDR_HI, default 2000, meaning the top of the mapped range (exclusive).
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of ACCESS cycles to wait for PREADY; 0 disables the timeout.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 cmd_valid  in  1  request present.
REQ-008 cmd_ready  out  1  request accepted when high together with cmd_valid.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  32  target address.
REQ-011 cmd_wdata  in  32  write data.
REQ-012 cmd_strb  in  4  write byte strobes.
REQ-013 rsp_valid  out  1  one-cycle completion pulse.
REQ-014 rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-015 rsp_err  out  1  PSLVERR, decode error or timeout.
REQ-016 rsp_timeout  out  1  transfer aborted by timeout.
REQ-017 PSEL, PENABLE, PWRITE  out  1 each  APB control.
REQ-018 PADDR, PWDATA  out  32 each  APB address and write data.
REQ-019 PSTRB  out  4  APB strobes.
REQ-020 PRDATA  in  32  APB read data.
REQ-021 PREADY, PSLVERR  in  1 each  APB completer response.

Function
REQ-022 SHALL implement states IDLE, SETUP, ACCESS and DONE.
REQ-023 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on the clk edge where cmd_valid and cmd_ready are both high.
REQ-024 SHALL register cmd_write, cmd_addr, cmd_wdata and cmd_strb on acceptance; later changes on the cmd_* inputs SHALL have no effect until the next acceptance.
REQ-025 On acceptance with the address in the range [ADDR_LO, ADDR_HI): SHALL go IDLE -> SETUP, with PSEL=1 and PENABLE=0 for exactly one cycle.
REQ-026 SHALL go SETUP -> ACCESS unconditionally, with PSEL=1 and PENABLE=1.
REQ-027 SHALL hold PADDR, PWRITE, PWDATA and PSTRB stable from SETUP through the last ACCESS cycle.
REQ-028 SHALL drive PSTRB=4'b0000 on reads.
REQ-029 In ACCESS with PREADY=1: SHALL capture PRDATA (reads only) and PSLVERR, then go to DONE; PSEL and PENABLE SHALL both be 0 in DONE.
REQ-030 In ACCESS with PREADY=0: SHALL remain in ACCESS and increment an ACCESS-cycle counter that is cleared on entry to SETUP.
REQ-031 If TIMEOUT != 0 and the counter reaches TIMEOUT-1 with PREADY=0: SHALL go to DONE with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-032 PREADY=1 on the timeout cycle SHALL take priority, giving a normal completion.
REQ-033 On acceptance with an out-of-range address: SHALL go IDLE -> DONE directly, with no PSEL assertion, rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-034 DONE SHALL last exactly one cycle, with rsp_valid=1, and then return to IDLE.
REQ-035 rsp_rdata, rsp_err and rsp_timeout SHALL hold their values until the next DONE.
REQ-036 rsp_err SHALL equal the captured PSLVERR on normal completion.
REQ-037 Minimum latency (in-range, zero-wait) SHALL be acceptance edge N, SETUP in cycle N+1, ACCESS in N+2, rsp_valid in N+3, cmd_ready in N+4.
REQ-038 PWDATA SHALL be driven 0 on reads; outside SETUP/ACCESS, PADDR, PWDATA and PSTRB SHALL retain their last values.

Reset
REQ-039 While rst=0: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0, cmd_ready=0.
REQ-040 Reset asserted mid-transfer (SETUP/ACCESS) SHALL drop PSEL/PENABLE immediately and produce no rsp_valid.
REQ-041 After rst deasserts: cmd_ready=1 in the first cycle.

Verification
REQ-042 Write addr=1004, wdata=0x000000A5, strb=4'h1, PREADY=1 -> one SETUP and one ACCESS cycle with PADDR=1004 and PSTRB=1, rsp_valid at N+3, rsp_err=0.
REQ-043 Read addr=1500, PREADY low for 3 ACCESS cycles then high with PRDATA=0x12345678 -> PENABLE high for 4 cycles, rsp_rdata=0x12345678, PSTRB=0.
REQ-044 Read addr=2000 -> PSEL never asserted, rsp_valid at N+1, rsp_err=1, rsp_timeout=0.
REQ-045 TIMEOUT=16, PREADY held 0 -> exactly 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-046 Write completing with PSLVERR=1 -> rsp_err=1; then rst pulsed low during the ACCESS of a following read -> PSEL=0 immediately, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_master.sv
// APB master: turns a single valid/ready command into one APB transfer and a one-cycle response pulse.
// Out-of-range addresses are answered locally, and a wait-state counter aborts transfers that stall too long.
module apb_master #(
    parameter logic [31:0] ADDR_LO = 32'd1000,
    parameter logic [31:0] ADDR_HI = 32'd2000,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_strb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSTRB,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          in_range;
    logic          tmo_hit;

    assign in_range  = (cmd_addr >= ADDR_LO) && (cmd_addr < ADDR_HI);
    assign tmo_hit   = (TIMEOUT != 0) && (cnt == CNT_MAX);
    // Gated by reset so the command port is closed while reset is held.
    assign cmd_ready = rst && (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (in_range) begin
                            state   <= SETUP;
                            cnt     <= '0;
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            PWRITE  <= cmd_write;
                            PADDR   <= cmd_addr;
                            PWDATA  <= cmd_write ? cmd_wdata : 32'h0;
                            PSTRB   <= cmd_write ? cmd_strb  : 4'h0;
                        end else begin
                            // Decode error: answered without touching the bus.
                            state       <= DONE;
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                        end
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        state       <= DONE;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
                    end else if (tmo_hit) begin
                        state       <= DONE;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: write, waited read, timeout, timeout-edge completion,
// decode errors at the range boundaries, slave error and reset mid-transfer.
module tb_apb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic        PREADY, PSLVERR;

    int n_assert = 0;
    int n_fail   = 0;
    int en_cnt;
    logic got;
    logic seen_vld;

    apb_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_ctrl", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, PSTRB}, 0);
        chk("rst_data", PADDR | PWDATA | rsp_rdata, 0);
        @(negedge clk); rst = 1'b1; #1;
        chk("ready_after_rst", cmd_ready, 1);

        // Zero-wait write to 1004
        cmd(1'b1, 32'd1004, 32'h0000_00A5, 4'h1); PREADY = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'hDEAD_0000; cmd_wdata = '1; cmd_strb = 4'hF;
        chk("w_setup", {PSEL, PENABLE, PWRITE, cmd_ready}, 4'b1010);
        chk("w_setup_paddr", PADDR, 1004);
        chk("w_setup_pstrb", PSTRB, 4'h1);
        chk("w_setup_pwdata", PWDATA, 32'hA5);
        @(negedge clk);
        chk("w_access", {PSEL, PENABLE, rsp_valid}, 3'b110);
        chk("w_access_paddr", PADDR, 1004);
        @(negedge clk);
        chk("w_done", {rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE}, 5'b10000);
        chk("w_done_rdata", rsp_rdata, 0);
        @(negedge clk);
        chk("w_idle", {cmd_ready, rsp_valid}, 2'b10);
        chk("w_paddr_kept", PADDR, 1004);

        // Read 1500 with 3 wait states
        cmd(1'b0, 32'd1500, 32'hFFFF_FFFF, 4'hF); PREADY = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("r_setup", {PSEL, PENABLE, PWRITE}, 3'b100);
        chk("r_pstrb", PSTRB, 0);
        chk("r_pwdata", PWDATA, 0);
        en_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (PSEL && PENABLE && !rsp_valid) en_cnt++;
            if (i == 3) begin PREADY = 1'b1; PRDATA = 32'h1234_5678; end
        end
        @(negedge clk);
        PREADY = 1'b0; PRDATA = '0;
        chk("r_penable_cycles", en_cnt, 4);
        chk("r_done", {rsp_valid, rsp_err, rsp_timeout, PENABLE}, 4'b1000);
        chk("r_rdata", rsp_rdata, 32'h1234_5678);
        @(negedge clk);
        chk("r_rdata_hold", rsp_rdata, 32'h1234_5678);
        chk("r_idle", {cmd_ready, rsp_valid}, 2'b10);

        // Timeout: PREADY never rises
        cmd(1'b0, 32'd1200, 32'h0, 4'h0);
        en_cnt = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (i == 0) cmd_valid = 1'b0;
            if (rsp_valid) got = 1'b1;
            else if (PENABLE) en_cnt++;
        end
        chk("to_seen", got, 1);
        chk("to_access_cycles", en_cnt, 16);
        chk("to_flags", {rsp_err, rsp_timeout, PSEL, PENABLE}, 4'b1100);
        chk("to_rdata", rsp_rdata, 0);
        @(negedge clk);

        // PREADY on the final allowed cycle completes normally
        cmd(1'b0, 32'd1300, 32'h0, 4'h0);
        en_cnt = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (i == 0) cmd_valid = 1'b0;
            if (rsp_valid) got = 1'b1;
            else if (PENABLE) begin
                en_cnt++;
                if (en_cnt == 16) begin PREADY = 1'b1; PRDATA = 32'h0BAD_BEEF; end
            end
        end
        PREADY = 1'b0;
        chk("edge_seen", got, 1);
        chk("edge_access_cycles", en_cnt, 16);
        chk("edge_flags", {rsp_err, rsp_timeout}, 2'b00);
        chk("edge_rdata", rsp_rdata, 32'h0BAD_BEEF);
        @(negedge clk);

        // Decode error at ADDR_HI
        cmd(1'b0, 32'd2000, 32'h0, 4'h0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("dec_hi", {rsp_valid, rsp_err, rsp_timeout, PSEL}, 4'b1100);
        chk("dec_hi_rdata", rsp_rdata, 0);
        chk("dec_paddr_kept", PADDR, 1300);
        @(negedge clk);
        chk("dec_hold", {rsp_valid, rsp_err, PSEL, cmd_ready}, 4'b0101);

        // Just below ADDR_LO is a decode error; ADDR_HI-1 is mapped
        cmd(1'b0, 32'd999, 32'h0, 4'h0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("dec_lo", {rsp_valid, rsp_err, PSEL}, 3'b110);
        @(negedge clk);
        cmd(1'b0, 32'd1999, 32'h0, 4'h0); PREADY = 1'b1; PRDATA = 32'hCAFE_F00D;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("top_setup", {PSEL, PENABLE}, 2'b10);
        @(negedge clk);
        @(negedge clk);
        chk("top_done", {rsp_valid, rsp_err}, 2'b10);
        chk("top_rdata", rsp_rdata, 32'hCAFE_F00D);
        PREADY = 1'b0;
        @(negedge clk);

        // Write ending with PSLVERR
        cmd(1'b1, 32'd1008, 32'h5555_AAAA, 4'hF); PREADY = 1'b1; PSLVERR = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("slverr_done", {rsp_valid, rsp_err, rsp_timeout}, 3'b110);
        PREADY = 1'b0; PSLVERR = 1'b0;
        @(negedge clk);

        // Reset during ACCESS of a read
        cmd(1'b0, 32'd1100, 32'h0, 4'h0);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_access", {PSEL, PENABLE}, 2'b11);
        #2 rst = 1'b0; #1;
        chk("mid_rst_drop", {PSEL, PENABLE, cmd_ready}, 3'b000);
        seen_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) seen_vld = 1'b1;
        end
        rst = 1'b1; #1;
        chk("post_rst_ready", cmd_ready, 1);
        @(negedge clk);
        if (rsp_valid) seen_vld = 1'b1;
        chk("no_rsp_after_rst", seen_vld, 0);
        chk("post_rst_state", {PSEL, PENABLE, rsp_err, cmd_ready}, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
